// File: rtl/rr_elastic_arbiter.sv
// Round-robin arbiter with burst limit feeding one registered output word.
// Owner keeps the grant for up to max_burst_p consecutive transfers.
module rr_elastic_arbiter #(
    parameter int width_p     = 10,
    parameter int num_req_p   = 4,
    parameter int max_burst_p = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_req_p*width_p-1:0]   data_i,
    input  logic [num_req_p-1:0]           valid_i,
    output logic [num_req_p-1:0]           ready_o,
    output logic                           valid_o,
    output logic [width_p-1:0]             data_o,
    output logic [$clog2(num_req_p)-1:0]   id_o,
    input  logic                           yumi_i
);

    localparam int id_w_lp = $clog2(num_req_p);
    localparam logic [3:0] burst_lp = 4'(max_burst_p);
    localparam logic [id_w_lp-1:0] last_lp = id_w_lp'(num_req_p - 1);

    logic [id_w_lp-1:0] owner_r;
    logic [3:0]         cnt_r;
    logic [id_w_lp-1:0] grant_id;
    logic               any_v;
    logic               accept_en;
    logic               xfer;
    logic               found;
    int                 idx;

    assign any_v     = |valid_i;
    assign accept_en = ~valid_o | yumi_i;
    assign xfer      = accept_en & any_v & ~reset_i;

    // Pick the owner while its burst budget lasts, else next valid after it.
    always_comb begin
        grant_id = owner_r;
        found    = 1'b0;
        idx      = 0;
        if (!(valid_i[owner_r] && (cnt_r < burst_lp))) begin
            for (int i = 1; i <= num_req_p; i++) begin
                idx = (int'(owner_r) + i) % num_req_p;
                if (!found && valid_i[idx]) begin
                    found    = 1'b1;
                    grant_id = id_w_lp'(idx);
                end
            end
        end
    end

    // Only the granted requester sees ready, and only when a slot is free.
    always_comb begin
        ready_o = '0;
        if (xfer) begin
            ready_o[grant_id] = 1'b1;
        end
    end

    // Output register and burst bookkeeping.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            id_o    <= '0;
            owner_r <= last_lp;
            cnt_r   <= burst_lp;
        end else if (accept_en) begin
            if (any_v) begin
                valid_o <= 1'b1;
                data_o  <= data_i[grant_id*width_p +: width_p];
                id_o    <= grant_id;
                if ((grant_id == owner_r) && (cnt_r < burst_lp)) begin
                    cnt_r <= cnt_r + 4'd1;
                end else begin
                    owner_r <= grant_id;
                    cnt_r   <= 4'd1;
                end
            end else begin
                valid_o <= 1'b0;
            end
        end
    end

    // Consumer may only take a word that is actually held.
    yumi_legal_a: assert property (
        @(posedge clk_i) disable iff (reset_i) !(yumi_i && !valid_o)
    ) else $error("yumi_i asserted while valid_o is low");

endmodule

// File: tb/tb_rr_elastic_arbiter.sv
// Bench for rr_elastic_arbiter: burst-2 and burst-1 builds, scoreboarded.
// Expected grant order comes from fixed tables; words checked on output.
module tb_rr_elastic_arbiter;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [3:0]  valid_i = '0;
    logic        hold_a = 1'b0;

    logic [3:0]  ready_a, ready_b;
    logic        valid_o_a, valid_o_b;
    logic [7:0]  data_o_a, data_o_b;
    logic [1:0]  id_o_a, id_o_b;
    logic        yumi_a, yumi_b;

    int n_checks = 0;
    int n_pass = 0;

    int          seq [4];
    logic [7:0]  base [4] = '{8'h10, 8'h50, 8'hA0, 8'hD0};
    int          exp_grant_q [$];
    word_t       word_q [$];

    assign yumi_a = valid_o_a & ~hold_a;
    assign yumi_b = valid_o_b;

    always #5 clk = ~clk;

    rr_elastic_arbiter #(
        .width_p(8), .num_req_p(4), .max_burst_p(2)
    ) dut_a (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i),
        .valid_i(valid_i), .ready_o(ready_a), .valid_o(valid_o_a),
        .data_o(data_o_a), .id_o(id_o_a), .yumi_i(yumi_a)
    );

    rr_elastic_arbiter #(
        .width_p(8), .num_req_p(4), .max_burst_p(1)
    ) dut_b (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i),
        .valid_i(valid_i), .ready_o(ready_b), .valid_o(valid_o_b),
        .data_o(data_o_b), .id_o(id_o_b), .yumi_i(yumi_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] payload(input int k);
        return base[k] + 8'(seq[k]);
    endfunction

    task automatic drive_data();
        for (int k = 0; k < 4; k++) data_i[k*8 +: 8] = payload(k);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        valid_i = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        for (int k = 0; k < 4; k++) seq[k] = 0;
        drive_data();
    endtask

    // Feed valid_i=vmask until every queued grant has been seen, then drain.
    task automatic run_stream(input bit use_b, input logic [3:0] vmask);
        int left;
        int budget;
        int g;
        logic [3:0] rdy;
        logic [3:0] xf;
        logic vo;
        logic [1:0] id;
        logic [7:0] dat;
        word_t w;
        left = exp_grant_q.size();
        budget = 200;
        for (int k = 0; k < 4; k++) seq[k] = 0;
        drive_data();
        valid_i = vmask;
        while ((left > 0 || word_q.size() > 0) && budget > 0) begin
            @(negedge clk);
            vo  = use_b ? valid_o_b : valid_o_a;
            id  = use_b ? id_o_b : id_o_a;
            dat = use_b ? data_o_b : data_o_a;
            rdy = use_b ? ready_b : ready_a;
            if (vo) begin
                if (word_q.size() == 0) begin
                    chk("extra_word", 32'(vo), 32'h0);
                end else begin
                    w = word_q.pop_front();
                    chk("word_id", 32'(id), 32'(w.id));
                    chk("word_data", 32'(dat), 32'(w.data));
                end
            end
            xf = rdy & valid_i;
            if (left > 0) begin
                g = exp_grant_q.pop_front();
                chk("grant", 32'(rdy), 32'(4'b0001 << g));
                w.id = 2'(g);
                w.data = payload(g);
                word_q.push_back(w);
                left--;
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) if (xf[k]) seq[k]++;
            if (left == 0) valid_i = '0;
            drive_data();
            budget--;
        end
        if (budget == 0) chk("stream_timeout", 32'h0, 32'h1);
        exp_grant_q.delete();
        word_q.delete();
    endtask

    initial begin
        // Reset state.
        do_reset();
        chk("rst_valid", 32'(valid_o_a), 32'h0);
        chk("rst_data", 32'(data_o_a), 32'h0);
        chk("rst_id", 32'(id_o_a), 32'h0);
        chk("rst_ready", 32'(ready_a), 32'h0);

        // Burst-1 build alternates between 1 and 3.
        exp_grant_q = '{1, 3, 1, 3};
        run_stream(1'b1, 4'b1010);

        // All requesters: pairs of grants in rotation.
        do_reset();
        exp_grant_q = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        run_stream(1'b0, 4'b1111);

        // Single requester keeps the channel every cycle.
        exp_grant_q = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
        run_stream(1'b0, 4'b0100);

        // Back-pressure: everything frozen while the consumer stalls.
        do_reset();
        hold_a = 1'b1;
        valid_i = 4'b1111;
        @(negedge clk);
        chk("hold_first_grant", 32'(ready_a), 32'h1);
        @(posedge clk);
        #1;
        seq[0]++;
        drive_data();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold_valid", 32'(valid_o_a), 32'h1);
            chk("hold_data", 32'(data_o_a), 32'h10);
            chk("hold_id", 32'(id_o_a), 32'h0);
            chk("hold_ready", 32'(ready_a), 32'h0);
        end
        hold_a = 1'b0;
        #1;
        chk("release_grant", 32'(ready_a), 32'h1);
        @(posedge clk);
        #1;
        seq[0]++;
        valid_i = '0;
        drive_data();
        @(negedge clk);
        chk("release_valid", 32'(valid_o_a), 32'h1);
        chk("release_id", 32'(id_o_a), 32'h0);
        chk("release_data", 32'(data_o_a), 32'h11);
        @(posedge clk);
        @(negedge clk);
        chk("idle_valid", 32'(valid_o_a), 32'h0);
        chk("idle_data_kept", 32'(data_o_a), 32'h11);

        // Reset in mid-stream discards the word and restarts at 0.
        do_reset();
        valid_i = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(valid_o_a), 32'h1);
        chk("pre_rst_id", 32'(id_o_a), 32'h1);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 32'(valid_o_a), 32'h0);
        chk("mid_rst_id", 32'(id_o_a), 32'h0);
        chk("mid_rst_data", 32'(data_o_a), 32'h0);
        @(negedge clk);
        chk("mid_rst_ready", 32'(ready_a), 32'h0);
        reset_i = 1'b0;
        #1;
        chk("post_rst_grant", 32'(ready_a), 32'h1);
        @(posedge clk);
        #1;
        valid_i = '0;
        @(negedge clk);
        chk("post_rst_id", 32'(id_o_a), 32'h0);
        chk("post_rst_valid", 32'(valid_o_a), 32'h1);
        repeat (2) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
